bf16_issue_ctrl: RTL and testbench

Request front end for the bfloat16 arithmetic unit. It sits directly upstream of op_mux and drives its opcode select and top-side operand interface. It accepts one operation at a time over a valid/ready request channel and holds the operands stable for an op-dependent number of cycles. It then captures op3 and the overflow flag, and returns them over a valid/ready response channel.

---
 rtl/data_type_pkg.sv | 34 +++
 rtl/op_intf.sv | 30 +++
 rtl/bf16_req_buf.sv | 38 +++
 rtl/bf16_issue_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_bf16_issue_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_type_pkg.sv
// data_type_pkg: shared bf16 datapath types, opcode encoding and the issue-controller
// state type used by bf16_issue_ctrl and its request buffer.
package data_type_pkg;

    // Opcode encoding seen by op_mux
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } issue_state_e;

    // One queued operation: opcode plus both operands
    typedef struct packed {
        logic [3:0] op;
        bf16_t      op1;
        bf16_t      op2;
    } issue_req_t;

    function automatic logic op_is_legal(logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/op_intf.sv
// op_intf: operand/result bundle between the issue front end and op_mux.
// bus_side drives op1/op2 and reads op3/overflow; op_side is the mirror view.
interface op_intf;

    logic       op1_sign;
    logic [7:0] op1_exp;
    logic [6:0] op1_frac;
    logic       op2_sign;
    logic [7:0] op2_exp;
    logic [6:0] op2_frac;
    logic       op3_sign;
    logic [7:0] op3_exp;
    logic [6:0] op3_frac;
    logic       overflow;

    modport bus_side (
        output op1_sign, op1_exp, op1_frac,
        output op2_sign, op2_exp, op2_frac,
        input  op3_sign, op3_exp, op3_frac,
        input  overflow
    );

    modport op_side (
        input  op1_sign, op1_exp, op1_frac,
        input  op2_sign, op2_exp, op2_frac,
        output op3_sign, op3_exp, op3_frac,
        output overflow
    );

endinterface

// File: rtl/bf16_req_buf.sv
// bf16_req_buf: single-entry valid/ready holding register for one issue request.
// Accepts only when empty; a pop and a push never coincide because in_ready is low when full.
module bf16_req_buf
    import data_type_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  issue_req_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output issue_req_t out_data
);

    logic       full_q;
    issue_req_t data_q;

    assign in_ready  = !full_q;
    assign out_valid = full_q;
    assign out_data  = data_q;

    // Fill when empty and offered, drain when the consumer takes the entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            if (in_valid && in_ready) begin
                full_q <= 1'b1;
                data_q <= in_data;
            end else if (out_valid && out_ready) begin
                full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bf16_issue_ctrl.sv
// bf16_issue_ctrl: request front end for the bf16 arithmetic unit. Accepts one operation,
// holds opcode and operands on op_mux for an op-dependent number of cycles, captures op3 and
// overflow, and returns them on the response channel.
// Build option: define BF16_ISSUE_PREFETCH_EN to add a one-entry request buffer so the next
// operation can be accepted while the current one is executing or waiting for rsp_ready.
module bf16_issue_ctrl
    import data_type_pkg::*;
#(
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned SUB_LAT = 1,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_op1,
    input  logic [15:0] req_op2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_err,
    output logic [3:0]  op_o,
    op_intf.bus_side    mux_intf
);

    // The 4-bit hold counter only covers latencies 1..15
    if (ADD_LAT == 0 || ADD_LAT > 15) begin : g_add_lat_chk
        $error("ADD_LAT must be in 1..15");
    end
    if (SUB_LAT == 0 || SUB_LAT > 15) begin : g_sub_lat_chk
        $error("SUB_LAT must be in 1..15");
    end
    if (MUL_LAT == 0 || MUL_LAT > 15) begin : g_mul_lat_chk
        $error("MUL_LAT must be in 1..15");
    end
    if (DIV_LAT == 0 || DIV_LAT > 15) begin : g_div_lat_chk
        $error("DIV_LAT must be in 1..15");
    end

    function automatic logic [3:0] lat_of(logic [3:0] op);
        logic [3:0] lat;
        case (op)
            OP_ADD:  lat = 4'(ADD_LAT);
            OP_SUB:  lat = 4'(SUB_LAT);
            OP_MUL:  lat = 4'(MUL_LAT);
            OP_DIV:  lat = 4'(DIV_LAT);
            default: lat = 4'd1;
        endcase
        return lat;
    endfunction

    issue_state_e state_q;
    logic [3:0]   cnt_q;
    logic [3:0]   op_q;
    bf16_t        op1_q;
    bf16_t        op2_q;
    logic         rsp_valid_q;
    bf16_t        rsp_result_q;
    logic         rsp_overflow_q;
    logic         rsp_err_q;

    issue_req_t   req_in;
    issue_req_t   start_req;
    logic         start_en;
    bf16_t        op3;

    assign req_in = {req_op, req_op1, req_op2};
    assign op3    = {mux_intf.op3_sign, mux_intf.op3_exp, mux_intf.op3_frac};

`ifdef BF16_ISSUE_PREFETCH_EN
    logic       rsp_hs;
    logic       buf_in_valid;
    logic       buf_in_ready;
    logic       buf_out_valid;
    issue_req_t buf_out_data;

    assign rsp_hs = (state_q == RESP) && rsp_ready;
    // On the response handshake with an empty buffer the request bypasses straight to the
    // working registers, so the buffer is never left holding an entry in IDLE.
    assign buf_in_valid = req_valid && (state_q != IDLE) && !rsp_hs;
    assign req_ready    = (state_q == IDLE) || buf_in_ready;

    bf16_req_buf u_req_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (req_in),
        .out_valid (buf_out_valid),
        .out_ready (rsp_hs),
        .out_data  (buf_out_data)
    );

    // Select which request (if any) is loaded into the working registers this cycle
    always_comb begin
        start_en  = 1'b0;
        start_req = req_in;
        if (state_q == IDLE) begin
            start_en = req_valid;
        end else if (rsp_hs) begin
            if (buf_out_valid) begin
                start_en  = 1'b1;
                start_req = buf_out_data;
            end else begin
                start_en = req_valid;
            end
        end
    end
`else
    assign req_ready = (state_q == IDLE);

    // Only IDLE accepts; requests go straight to the working registers
    always_comb begin
        start_en  = (state_q == IDLE) && req_valid;
        start_req = req_in;
    end
`endif

    // Issue FSM with registered opcode, operands and response fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            op_q           <= '0;
            op1_q          <= '0;
            op2_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        rsp_result_q   <= op3;
                        rsp_overflow_q <= mux_intf.overflow;
                        rsp_err_q      <= 1'b0;
                        rsp_valid_q    <= 1'b1;
                        state_q        <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A new operation overrides the IDLE/RESP transition above
            if (start_en) begin
                op_q  <= start_req.op;
                op1_q <= start_req.op1;
                op2_q <= start_req.op2;
                if (op_is_legal(start_req.op)) begin
                    cnt_q       <= lat_of(start_req.op) - 4'd1;
                    rsp_valid_q <= 1'b0;
                    state_q     <= EXEC;
                end else begin
                    rsp_result_q   <= '0;
                    rsp_overflow_q <= 1'b0;
                    rsp_err_q      <= 1'b1;
                    rsp_valid_q    <= 1'b1;
                    state_q        <= RESP;
                end
            end
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_err      = rsp_err_q;
    assign op_o         = op_q;

    assign mux_intf.op1_sign = op1_q.sign;
    assign mux_intf.op1_exp  = op1_q.exp;
    assign mux_intf.op1_frac = op1_q.frac;
    assign mux_intf.op2_sign = op2_q.sign;
    assign mux_intf.op2_exp  = op2_q.exp;
    assign mux_intf.op2_frac = op2_q.frac;

endmodule

// File: tb/tb_bf16_issue_ctrl.sv
// tb_bf16_issue_ctrl: scoreboard bench for bf16_issue_ctrl with a behavioural op_mux stand-in
// whose result only becomes correct after the operands have been held for the op latency.
module tb_bf16_issue_ctrl;
    import data_type_pkg::*;

    localparam int unsigned ADD_LAT = 1;
    localparam int unsigned SUB_LAT = 1;
    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DIV_LAT = 4;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        err;
        int unsigned accept;
        int unsigned lat;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_op1;
    logic [15:0] req_op2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_overflow;
    logic        rsp_err;
    logic [3:0]  op_o;

    op_intf mux_if ();

    bf16_issue_ctrl #(
        .ADD_LAT (ADD_LAT),
        .SUB_LAT (SUB_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_err      (rsp_err),
        .op_o         (op_o),
        .mux_intf     (mux_if)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    sb_entry_t sb[$];

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic: known bf16 vectors, otherwise an arbitrary deterministic mix
    function automatic logic [16:0] alu_model(logic [3:0] op, logic [15:0] a, logic [15:0] b);
        if (op == OP_ADD && a == 16'h3F80 && b == 16'h4000) return {1'b0, 16'h4040};
        if (op == OP_SUB && a == 16'h4040 && b == 16'h3F80) return {1'b0, 16'h4000};
        if (op == OP_MUL && a == 16'h4040 && b == 16'h4000) return {1'b0, 16'h40C0};
        if (op == OP_DIV && a == 16'h3F80 && b == 16'h4000) return {1'b0, 16'h3F00};
        if (op == OP_MUL && a == 16'h7F7F && b == 16'h4000) return {1'b1, 16'h7F80};
        return {a[15] ^ b[15], (a ^ {b[7:0], b[15:8]}) + {12'd0, op}};
    endfunction

    function automatic int unsigned lat_model(logic [3:0] op);
        case (op)
            4'h0:    return ADD_LAT;
            4'h1:    return SUB_LAT;
            4'h2:    return MUL_LAT;
            4'h3:    return DIV_LAT;
            default: return 1;
        endcase
    endfunction

    function automatic logic legal_model(logic [3:0] op);
        return op <= 4'h3;
    endfunction

    // op_mux stand-in: outputs are corrupted until inputs have been stable for the op latency
    logic [15:0] mux_a;
    logic [15:0] mux_b;
    logic [16:0] mux_y;
    logic        mux_settled;
    logic [35:0] last_in;
    int unsigned stab;

    initial begin
        last_in = '0;
        stab    = 0;
    end

    assign mux_a = {mux_if.op1_sign, mux_if.op1_exp, mux_if.op1_frac};
    assign mux_b = {mux_if.op2_sign, mux_if.op2_exp, mux_if.op2_frac};
    assign mux_y = alu_model(op_o, mux_a, mux_b);
    assign mux_settled = (stab >= lat_model(op_o));
    assign {mux_if.op3_sign, mux_if.op3_exp, mux_if.op3_frac} =
        mux_settled ? mux_y[15:0] : (mux_y[15:0] ^ 16'h5A5A);
    assign mux_if.overflow = mux_settled ? mux_y[16] : ~mux_y[16];

    always @(negedge clk) begin
        if ({op_o, mux_a, mux_b} != last_in) stab <= 1;
        else if (stab < 64) stab <= stab + 1;
        last_in <= {op_o, mux_a, mux_b};
    end

    // Response monitor: checks hold stability, payload and launch-to-valid latency
    initial begin
        bit          in_rsp;
        int unsigned first_cyc;
        int unsigned last_hs;
        int unsigned launch;
        logic [17:0] snap;
        sb_entry_t   e;
        in_rsp  = 0;
        last_hs = 0;
        first_cyc = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_rsp = 0;
            end else if (rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp    = 1;
                    first_cyc = cyc;
                    snap      = {rsp_result, rsp_overflow, rsp_err};
                end
`ifndef BF16_ISSUE_PREFETCH_EN
                check_eq("req_ready_busy", {31'd0, req_ready}, 32'd0);
`endif
                if (!rsp_ready) begin
                    if (cyc != first_cyc)
                        check_eq("rsp_hold", {14'd0, rsp_result, rsp_overflow, rsp_err},
                                 {14'd0, snap});
                end else begin
                    if (sb.size() == 0) begin
                        check_eq("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        launch = (e.accept > last_hs) ? e.accept : last_hs;
                        check_eq("rsp_result", {16'd0, rsp_result}, {16'd0, e.res});
                        check_eq("rsp_overflow", {31'd0, rsp_overflow}, {31'd0, e.ovf});
                        check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        check_eq("rsp_latency", first_cyc - launch, e.lat);
                    end
                    last_hs = cyc + 1;
                    in_rsp  = 0;
                end
            end
        end
    end

    // Present one request, wait for acceptance, record the expected response
    task automatic send(logic [3:0] op, logic [15:0] a, logic [15:0] b);
        sb_entry_t   e;
        logic [16:0] y;
        int          n;
        req_valid = 1'b1;
        req_op    = op;
        req_op1   = a;
        req_op2   = b;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check_eq("req_accept_timeout", {31'd0, req_ready}, 32'd1);
        end else begin
            y = alu_model(op, a, b);
            e.accept = cyc + 1;
            if (legal_model(op)) begin
                e.res = y[15:0];
                e.ovf = y[16];
                e.err = 1'b0;
                e.lat = lat_model(op);
            end else begin
                e.res = 16'h0000;
                e.ovf = 1'b0;
                e.err = 1'b1;
                e.lat = 0;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [3:0]  rop;
        req_valid = 1'b0;
        req_op    = '0;
        req_op1   = '0;
        req_op2   = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        #2;
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
        check_eq("rst_rsp_overflow", {31'd0, rsp_overflow}, 32'd0);
        check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rst_op_o", {28'd0, op_o}, 32'd0);
        check_eq("rst_mux_op1", {16'd0, mux_a}, 32'd0);
        check_eq("rst_mux_op2", {16'd0, mux_b}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Directed arithmetic vectors
        send(OP_ADD, 16'h3F80, 16'h4000);
        drain();
        send(OP_SUB, 16'h4040, 16'h3F80);
        drain();
        send(OP_MUL, 16'h4040, 16'h4000);
        drain();
        send(OP_DIV, 16'h3F80, 16'h4000);
        drain();

        // Overflow with response back-pressure
        rsp_ready = 1'b0;
        send(OP_MUL, 16'h7F7F, 16'h4000);
        n = 0;
        while (!rsp_valid && n < 32) begin
            @(negedge clk);
            n++;
        end
        check_eq("hold_rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        repeat (5) @(negedge clk);
        check_eq("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();

        // Illegal opcode
        send(4'hF, 16'h1234, 16'h5678);
        drain();

        // Asynchronous reset in the middle of a divide
        send(OP_DIV, 16'h4000, 16'h3F80);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("midrst_op_o", {28'd0, op_o}, 32'd0);
        check_eq("midrst_mux_op1", {16'd0, mux_a}, 32'd0);
        check_eq("midrst_rsp_err", {31'd0, rsp_err}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(OP_ADD, 16'h4000, 16'h4040);
        drain();

        // Back-to-back requests: buffered with prefetch, stalled until IDLE without
        send(OP_ADD, 16'h3F80, 16'h4000);
        send(OP_ADD, 16'h4000, 16'h4040);
        drain();
        send(OP_DIV, 16'h3F80, 16'h4000);
        send(4'h9, 16'h1111, 16'h2222);
        send(4'hF, 16'h3333, 16'h4444);
        drain();

        // Random mix of legal and illegal operations
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 5))
                0:       rop = OP_ADD;
                1:       rop = OP_SUB;
                2:       rop = OP_MUL;
                3:       rop = OP_DIV;
                4:       rop = 4'h9;
                default: rop = 4'hF;
            endcase
            send(rop, 16'($urandom), 16'($urandom));
            if (i % 3 == 0) drain();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
